// File: rtl/prod_acc_pkg.sv
// Shared types and helpers for the product accumulator: FSM state encoding,
// counter width and the signed saturation limits for an arbitrary width.
package prod_acc_pkg;

  typedef enum logic {
    ACCUM = 1'b0,
    DONE  = 1'b1
  } state_t;

  // Widest accumulator the limit helpers can describe; callers slice the low bits.
  localparam int LIM_W = 128;

  function automatic int acc_cnt_w(input int max_terms);
    return $clog2(max_terms + 1);
  endfunction

  // Largest positive two's-complement value of width w, zero-extended to LIM_W.
  function automatic logic [LIM_W-1:0] sat_max(input int w);
    return (LIM_W'(1) << (w - 1)) - LIM_W'(1);
  endfunction

  // Most negative value of width w; its low w bits are 1 followed by zeros.
  function automatic logic [LIM_W-1:0] sat_min(input int w);
    return ~sat_max(w);
  endfunction

endpackage

// File: rtl/prod_acc_if.sv
// Product stream in, dot-product result out. The producer/consumer side owns
// the master modport, the accumulator owns the slave modport.
interface prod_acc_if #(
  parameter int ACC_W = 40,
  parameter int CNT_W = 9
);
  logic signed [31:0]      i_prod;
  logic                    i_valid;
  logic                    i_last;
  logic                    o_ready;
  logic signed [ACC_W-1:0] o_acc;
  logic [CNT_W-1:0]        o_count;
  logic                    o_ovf;
  logic                    o_valid;
  logic                    i_ready;

  modport master (
    output i_prod, i_valid, i_last, i_ready,
    input  o_ready, o_acc, o_count, o_ovf, o_valid
  );

  modport slave (
    input  i_prod, i_valid, i_last, i_ready,
    output o_ready, o_acc, o_count, o_ovf, o_valid
  );
endinterface

// File: rtl/acc_sat_add.sv
// Combinational signed adder of two ACC_W operands with overflow detection and
// optional clamping to the signed range.
module acc_sat_add
  import prod_acc_pkg::*;
#(
  parameter int ACC_W    = 40,
  parameter bit SATURATE = 1'b1
) (
  input  logic signed [ACC_W-1:0] a,
  input  logic signed [ACC_W-1:0] b,
  output logic signed [ACC_W-1:0] sum,
  output logic                    ovf
);

  localparam logic [LIM_W-1:0] MAX_L = sat_max(ACC_W);
  localparam logic [LIM_W-1:0] MIN_L = sat_min(ACC_W);
  localparam logic signed [ACC_W-1:0] POS_LIM = MAX_L[ACC_W-1:0];
  localparam logic signed [ACC_W-1:0] NEG_LIM = MIN_L[ACC_W-1:0];

  logic [ACC_W:0] wide;

  // One guard bit: the result left the signed range when the top two bits differ.
  assign wide = {a[ACC_W-1], a} + {b[ACC_W-1], b};
  assign ovf  = wide[ACC_W] ^ wide[ACC_W-1];

  // NOTE: every output of a combinational block gets a default first so no latch is inferred.
  always_comb begin
    sum = wide[ACC_W-1:0];
    if (ovf && SATURATE) begin
      sum = wide[ACC_W] ? NEG_LIM : POS_LIM;
    end
  end

endmodule

// File: rtl/prod_accumulator.sv
// Two-stage signed accumulator for multiplier products: S1 registers the beat,
// S2 folds it into the burst sum, which is held until the consumer takes it.
module prod_accumulator
  import prod_acc_pkg::*;
#(
  parameter int ACC_W     = 40,
  parameter int MAX_TERMS = 256,
  parameter bit SATURATE  = 1'b1
) (
  input logic         i_clk,
  input logic         i_rst,
  prod_acc_if.slave   bus
);

  localparam int CNT_W = acc_cnt_w(MAX_TERMS);
  localparam logic [CNT_W:0] TERM_LIMIT = (CNT_W + 1)'(MAX_TERMS);

  state_t                  state, state_nxt;
  logic signed [31:0]      s1_prod;
  logic                    s1_last_eff;
  logic                    s1_vld;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] add_sum;
  logic signed [ACC_W-1:0] prod_ext;
  logic [CNT_W-1:0]        cnt;
  logic                    ovf;
  logic                    add_ovf;
  logic                    accept;
  logic                    last_eff;
  logic                    clear;
  logic [CNT_W:0]          count_incl;

  // Ready depends only on registered state, never on the consumer's i_ready.
  assign bus.o_ready = (state == ACCUM) && !(s1_vld && s1_last_eff);
  assign accept      = bus.i_valid && bus.o_ready;

  // A beat still waiting in S1 already counts toward the term limit.
  assign count_incl = {1'b0, cnt} + (CNT_W + 1)'(s1_vld) + (CNT_W + 1)'(1);
  assign last_eff   = bus.i_last || (count_incl == TERM_LIMIT);

  // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      s1_vld      <= 1'b0;
      s1_prod     <= '0;
      s1_last_eff <= 1'b0;
    end else begin
      s1_vld <= accept;
      if (accept) begin
        s1_prod     <= bus.i_prod;
        s1_last_eff <= last_eff;
      end
    end
  end

  assign prod_ext = {{(ACC_W - 32){s1_prod[31]}}, s1_prod};

  acc_sat_add #(
    .ACC_W    (ACC_W),
    .SATURATE (SATURATE)
  ) u_add (
    .a   (acc),
    .b   (prod_ext),
    .sum (add_sum),
    .ovf (add_ovf)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= ACCUM;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    clear     = 1'b0;
    case (state)
      ACCUM: begin
        if (s1_vld && s1_last_eff) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (bus.i_ready) begin
          state_nxt = ACCUM;
          clear     = 1'b1;
        end
      end
    endcase
  end

  // S1 is always empty in DONE, so the sum cannot move while the result is held.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      acc <= '0;
      cnt <= '0;
      ovf <= 1'b0;
    end else if (clear) begin
      acc <= '0;
      cnt <= '0;
      ovf <= 1'b0;
    end else if (s1_vld) begin
      acc <= add_sum;
      cnt <= cnt + CNT_W'(1);
      ovf <= ovf | add_ovf;
    end
  end

  assign bus.o_acc   = acc;
  assign bus.o_count = cnt;
  assign bus.o_ovf   = ovf;
  assign bus.o_valid = (state == DONE);

endmodule
